// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
// The optional BTB_BYPASS_EN build forwards same-cycle updates to lookups.
package btb_predictor_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int TAG_W_DEF = 6;
    localparam int CNT_W_DEF = 2;

    typedef struct packed {
        logic                 v;
        logic [TAG_W_DEF-1:0] tag;
        logic [PC_W_DEF-1:0]  ta;
        logic [CNT_W_DEF-1:0] cnt;
    } BTB_entry;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } BTB_FSM_states;

    localparam logic [CNT_W_DEF-1:0] CNT_WEAK_TAKEN = 2'b10;

endpackage

// File: rtl/btb_sat_cnt.sv
// Saturating up/down counter step: +1 on taken, -1 on not taken, clamped at the ends.
module btb_sat_cnt #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != '1) cnt_next = cnt + CNT_W'(1);
        end else begin
            if (cnt != '0) cnt_next = cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with saturating direction counters and a one-entry-per-cycle invalidation sweep.
// Define BTB_BYPASS_EN to forward a same-index update into the same-cycle lookup.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int N_ENTRIES = 16,
    parameter int PC_W      = 32,
    parameter int TAG_W     = 6,
    parameter int CNT_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lk_valid,
    input  logic [PC_W-1:0] lk_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush,
    output logic            ready
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam logic [0:0] ST_SWEEP = SWEEP;
    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(N_ENTRIES - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;

    logic             v_mem   [N_ENTRIES];
    logic [TAG_W-1:0] tag_mem [N_ENTRIES];
    logic [PC_W-1:0]  ta_mem  [N_ENTRIES];
    logic [CNT_W-1:0] cnt_mem [N_ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             upd_en, upd_hit, wr_en;
    logic [CNT_W-1:0] cnt_sat;

    logic             new_v;
    logic [TAG_W-1:0] new_tag;
    logic [PC_W-1:0]  new_ta;
    logic [CNT_W-1:0] new_cnt;

    logic             rd_v;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_ta;
    logic [CNT_W-1:0] rd_cnt;
    logic             entry_hit;

    // Bits [1:0] and anything above the partial tag take no part in indexing or matching.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc, upd_pc};

    assign ready   = (state == ST_IDLE);
    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // A flush in the same IDLE cycle wins over the update.
    assign upd_en  = upd_valid & ready & ~flush;
    assign upd_hit = v_mem[upd_idx] & (tag_mem[upd_idx] == upd_tag);

    btb_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
        .cnt      (cnt_mem[upd_idx]),
        .taken    (upd_taken),
        .cnt_next (cnt_sat)
    );

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        new_v   = v_mem[upd_idx];
        new_tag = tag_mem[upd_idx];
        new_ta  = ta_mem[upd_idx];
        new_cnt = cnt_mem[upd_idx];
        if (upd_en) begin
            if (upd_hit) begin
                wr_en   = 1'b1;
                new_cnt = cnt_sat;
                if (upd_taken) new_ta = upd_target;
            end else if (upd_taken) begin
                wr_en   = 1'b1;
                new_v   = 1'b1;
                new_tag = upd_tag;
                new_ta  = upd_target;
                new_cnt = CNT_WEAK;
            end
        end
    end

    always_comb begin
        rd_v   = v_mem[lk_idx];
        rd_tag = tag_mem[lk_idx];
        rd_ta  = ta_mem[lk_idx];
        rd_cnt = cnt_mem[lk_idx];
`ifdef BTB_BYPASS_EN
        if (upd_en && (upd_idx == lk_idx)) begin
            rd_v   = new_v;
            rd_tag = new_tag;
            rd_ta  = new_ta;
            rd_cnt = new_cnt;
        end
`endif
    end

    assign entry_hit   = ready & lk_valid & rd_v & (rd_tag == lk_tag);
    assign pred_hit    = entry_hit;
    assign pred_taken  = entry_hit & rd_cnt[CNT_W-1];
    assign pred_target = entry_hit ? rd_ta : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SWEEP;
            ptr   <= '0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    if (ptr == PTR_LAST) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    if (flush) begin
                        state <= ST_SWEEP;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; the sweep clears V, and TAG/TA/CNT are only read behind V.
    always_ff @(posedge clk) begin
        if (state == ST_SWEEP) begin
            v_mem[ptr] <= 1'b0;
        end else if (wr_en && !rst) begin
            v_mem[upd_idx]   <= new_v;
            tag_mem[upd_idx] <= new_tag;
            ta_mem[upd_idx]  <= new_ta;
            cnt_mem[upd_idx] <= new_cnt;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios plus randomized traffic against a behavioural model.
module tb_btb_predictor;

    localparam int N        = 16;
    localparam int PC_W     = 32;
    localparam int TAG_W    = 6;
    localparam int CNT_W    = 2;
    localparam int IDX_W    = $clog2(N);
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int CNT_HALF = 1 << (CNT_W - 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            lk_valid = 1'b0;
    logic [PC_W-1:0] lk_pc = '0;
    logic            pred_hit, pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid = 1'b0;
    logic [PC_W-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic [PC_W-1:0] upd_target = '0;
    logic            flush = 1'b0;
    logic            ready;

    btb_predictor #(.N_ENTRIES(N), .PC_W(PC_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .lk_valid    (lk_valid),
        .lk_pc       (lk_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: one record per index plus the number of sweep cycles still to go.
    bit              m_valid [N];
    int unsigned     m_tag   [N];
    logic [PC_W-1:0] m_tgt   [N];
    int              m_cnt   [N];
    int              sweep_left;

    bit `ifdef BTB_BYPASS_EN bypass_on = 1'b1; `else bypass_on = 1'b0; `endif

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [PC_W-1:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned tag_of(input logic [PC_W-1:0] pc);
        return (pc >> (IDX_W + 2)) % (1 << TAG_W);
    endfunction

    // Entry at upd_pc's index as it would look after the current update is applied.
    task automatic model_post(output bit v, output int unsigned tg, output logic [PC_W-1:0] ta, output int c);
        int i = idx_of(upd_pc);
        v  = m_valid[i];
        tg = m_tag[i];
        ta = m_tgt[i];
        c  = m_cnt[i];
        if (v && tg == tag_of(upd_pc)) begin
            if (upd_taken) begin
                c  = (c < CNT_MAX) ? c + 1 : c;
                ta = upd_target;
            end else begin
                c = (c > 0) ? c - 1 : 0;
            end
        end else if (upd_taken) begin
            v  = 1'b1;
            tg = tag_of(upd_pc);
            ta = upd_target;
            c  = CNT_HALF;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        sweep_left = N;
    endtask

    // One clock: check outputs for the current inputs, then advance DUT and model together.
    task automatic step();
        bit              e_v, p_v, upd_eff, e_hit;
        int unsigned     e_tg, p_tg;
        logic [PC_W-1:0] e_ta, p_ta;
        int              e_c, p_c, li;
        #1;
        li      = idx_of(lk_pc);
        upd_eff = upd_valid && sweep_left == 0 && !flush;
        model_post(p_v, p_tg, p_ta, p_c);
        e_v  = m_valid[li];
        e_tg = m_tag[li];
        e_ta = m_tgt[li];
        e_c  = m_cnt[li];
        if (bypass_on && upd_eff && idx_of(upd_pc) == li) begin
            e_v  = p_v;
            e_tg = p_tg;
            e_ta = p_ta;
            e_c  = p_c;
        end
        e_hit = (sweep_left == 0) && lk_valid && e_v && (e_tg == tag_of(lk_pc));
        if (chk_en) begin
            check("ready", ready, (sweep_left == 0));
            check("pred_hit", pred_hit, e_hit);
            check("pred_taken", pred_taken, e_hit && e_c >= CNT_HALF);
            check("pred_target", pred_target, e_hit ? e_ta : '0);
        end
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (flush) begin
            clear_model();
        end else if (upd_valid) begin
            li          = idx_of(upd_pc);
            m_valid[li] = p_v;
            m_tag[li]   = p_tg;
            m_tgt[li]   = p_ta;
            m_cnt[li]   = p_c;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        flush     = 1'b0;
        lk_valid  = 1'b0;
        lk_pc     = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        upd_target = '0;
    endtask

    task automatic upd_step(input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tgt);
        idle_inputs();
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        lk_valid   = 1'b1;
        lk_pc      = $urandom;
        step();
    endtask

    task automatic look(input string name, input logic [PC_W-1:0] pc, input logic e_hit,
                        input logic e_taken, input logic [PC_W-1:0] e_tgt);
        idle_inputs();
        lk_valid = 1'b1;
        lk_pc    = pc;
        #1;
        check({name, "_hit"}, pred_hit, e_hit);
        check({name, "_taken"}, pred_taken, e_taken);
        check({name, "_target"}, pred_target, e_tgt);
        step();
    endtask

    // Counts cycles with ready low (flush and lookups toggled to show both are ignored); bounded.
    task automatic count_sweep(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            idle_inputs();
            flush    = 1'($urandom);
            lk_valid = 1'($urandom);
            lk_pc    = $urandom;
            step();
            n++;
        end
        check(name, n, N);
    endtask

    function automatic logic [PC_W-1:0] rand_pc();
        logic [PC_W-1:0] pc;
        pc = $urandom;
        pc[IDX_W+TAG_W+1:IDX_W+2] = TAG_W'($urandom_range(0, 3));
        return pc;
    endfunction

    initial begin
        clear_model();
        for (int i = 0; i < N; i++) begin
            m_tag[i] = 0;
            m_tgt[i] = '0;
            m_cnt[i] = 0;
        end

        // Power-on reset; outputs are unknown until the first edge.
        idle_inputs();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", ready, 1'b0);
        count_sweep("reset_sweep_len");

        // Allocation and counter saturation on 0x40.
        upd_step(32'h40, 1'b1, 32'h100);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        upd_step(32'h40, 1'b0, '0);
        look("sat_nt1", 32'h40, 1'b1, 1'b0, 32'h100);
        upd_step(32'h40, 1'b0, '0);
        look("sat_nt2", 32'h40, 1'b1, 1'b0, 32'h100);
        upd_step(32'h40, 1'b0, '0);
        upd_step(32'h40, 1'b1, 32'h100);
        look("sat_floor_a", 32'h40, 1'b1, 1'b0, 32'h100);
        upd_step(32'h40, 1'b1, 32'h100);
        look("sat_floor_b", 32'h40, 1'b1, 1'b1, 32'h100);
        upd_step(32'h40, 1'b1, 32'h100);
        upd_step(32'h40, 1'b1, 32'h104);
        upd_step(32'h40, 1'b0, '0);
        look("sat_ceil", 32'h40, 1'b1, 1'b1, 32'h104);
        upd_step(32'h40, 1'b0, '0);
        look("sat_down", 32'h40, 1'b1, 1'b0, 32'h104);

        // Counter is weakly not-taken; taken update and lookup in the same cycle.
        idle_inputs();
        lk_valid   = 1'b1;
        lk_pc      = 32'h40;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h100;
        #1;
        check("same_cycle_taken", pred_taken, bypass_on);
        step();
        look("after_same", 32'h40, 1'b1, 1'b1, 32'h100);

        // Aliasing: same index, different tag replaces the entry.
        upd_step(32'h40 + (1 << (IDX_W + 2)), 1'b1, 32'h200);
        look("alias_old", 32'h40, 1'b0, 1'b0, '0);
        look("alias_new", 32'h40 + (1 << (IDX_W + 2)), 1'b1, 1'b1, 32'h200);

        // Flush with a concurrent update: update is dropped, everything invalidated.
        idle_inputs();
        flush      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h300;
        upd_taken  = 1'b1;
        upd_target = 32'h400;
        step();
        check("flush_ready", ready, 1'b0);
        count_sweep("flush_sweep_len");
        look("flush_cleared", 32'h40 + (1 << (IDX_W + 2)), 1'b0, 1'b0, '0);
        look("flush_upd_dropped", 32'h300, 1'b0, 1'b0, '0);

        // Reset at sweep cycle 5 restarts a full sweep.
        idle_inputs();
        flush = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_sweep("rst_mid_sweep_len");

        // Randomized traffic over a small tag space so hits, aliasing and saturation all occur.
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            lk_valid   = 1'($urandom);
            upd_valid  = 1'($urandom);
            lk_pc      = rand_pc();
            upd_pc     = ($urandom_range(0, 3) == 0) ? lk_pc : rand_pc();
            upd_taken  = 1'($urandom);
            upd_target = $urandom;
            flush      = ($urandom_range(0, 299) == 0);
            rst        = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
